// File: rtl/mig_req_queue_if.sv
// Request/write-data bus between the AXI-side front end, the queue and the MIG consumer.
// The master modport drives the push side and pop strobes; the slave modport is the queue itself.
interface mig_req_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  req_wen;
  logic [31:0]           req_waddr;
  logic                  req_wrd_bwt;
  logic [127:0]          req_wdata;
  logic                  req_wfull;
  logic [DEPTH_LOG2:0]   req_count;
  logic                  req_rnext;
  logic                  req_rqempty;
  logic [31:0]           req_qraddr;
  logic                  req_rd_bwt;
  logic                  wdq_rnext;
  logic                  wdq_rqempty;
  logic [127:0]          wdq_rdata;
  logic                  q_err;

  modport master (
    output req_wen, req_waddr, req_wrd_bwt, req_wdata, req_rnext, wdq_rnext,
    input  req_wfull, req_count, req_rqempty, req_qraddr, req_rd_bwt,
           wdq_rqempty, wdq_rdata, q_err
  );

  modport slave (
    input  req_wen, req_waddr, req_wrd_bwt, req_wdata, req_rnext, wdq_rnext,
    output req_wfull, req_count, req_rqempty, req_qraddr, req_rd_bwt,
           wdq_rqempty, wdq_rdata, q_err
  );
endinterface

// File: rtl/mig_req_queue.sv
// Show-ahead request queue and write-data queue feeding the MIG interface stage.
// Define MIG_REQ_QUEUE_ERRCHK_EN to build the sticky q_err protocol-error register.
module mig_req_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic            mclk,
  input  logic            mrst_n,
  mig_req_queue_if.slave  q
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [32:0]  rq_mem_q [DEPTH];
  logic [32:0]  rq_mem_d [DEPTH];
  logic [127:0] wq_mem_q [DEPTH];
  logic [127:0] wq_mem_d [DEPTH];

  logic [PW-1:0] rq_wp_q, rq_wp_d, rq_rp_q, rq_rp_d;
  logic [PW-1:0] wq_wp_q, wq_wp_d, wq_rp_q, wq_rp_d;

  logic rq_empty, rq_full, wq_empty, wq_full;
  logic wfull, acc, rq_pop, wq_pop;

  always_comb begin
    rq_empty = (rq_wp_q == rq_rp_q);
    wq_empty = (wq_wp_q == wq_rp_q);
    rq_full  = (rq_wp_q[PW-2:0] == rq_rp_q[PW-2:0]) && (rq_wp_q[PW-1] != rq_rp_q[PW-1]);
    wq_full  = (wq_wp_q[PW-2:0] == wq_rp_q[PW-2:0]) && (wq_wp_q[PW-1] != wq_rp_q[PW-1]);
    // A read needs no data slot, so only writes are blocked by a full data queue.
    wfull    = rq_full | (~q.req_wrd_bwt & wq_full);
    acc      = q.req_wen & ~wfull;
    rq_pop   = q.req_rnext & ~rq_empty;
    wq_pop   = q.wdq_rnext & ~wq_empty;
  end

  always_comb begin
    rq_mem_d = rq_mem_q;
    wq_mem_d = wq_mem_q;
    rq_wp_d  = rq_wp_q;
    rq_rp_d  = rq_rp_q;
    wq_wp_d  = wq_wp_q;
    wq_rp_d  = wq_rp_q;
    if (acc) begin
      rq_mem_d[rq_wp_q[PW-2:0]] = {q.req_wrd_bwt, q.req_waddr};
      rq_wp_d = rq_wp_q + 1'b1;
      if (!q.req_wrd_bwt) begin
        wq_mem_d[wq_wp_q[PW-2:0]] = q.req_wdata;
        wq_wp_d = wq_wp_q + 1'b1;
      end
    end
    if (rq_pop) rq_rp_d = rq_rp_q + 1'b1;
    if (wq_pop) wq_rp_d = wq_rp_q + 1'b1;
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      rq_mem_q <= '{default: '0};
      wq_mem_q <= '{default: '0};
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      wq_wp_q  <= '0;
      wq_rp_q  <= '0;
    end else begin
      rq_mem_q <= rq_mem_d;
      wq_mem_q <= wq_mem_d;
      rq_wp_q  <= rq_wp_d;
      rq_rp_q  <= rq_rp_d;
      wq_wp_q  <= wq_wp_d;
      wq_rp_q  <= wq_rp_d;
    end
  end

  assign q.req_wfull   = wfull;
  assign q.req_count   = rq_wp_q - rq_rp_q;
  assign q.req_rqempty = rq_empty;
  assign q.wdq_rqempty = wq_empty;
  assign q.req_qraddr  = rq_mem_q[rq_rp_q[PW-2:0]][31:0];
  assign q.req_rd_bwt  = rq_mem_q[rq_rp_q[PW-2:0]][32];
  assign q.wdq_rdata   = wq_mem_q[wq_rp_q[PW-2:0]];

`ifdef MIG_REQ_QUEUE_ERRCHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (q.req_wen & wfull) | (q.req_rnext & rq_empty) | (q.wdq_rnext & wq_empty);
  end

  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign q.q_err = err_q;
`else
  assign q.q_err = 1'b0;
`endif
endmodule

// File: tb/tb_mig_req_queue.sv
// Directed self-checking bench for mig_req_queue: fill/drain, split full, wrap, empty pop, async reset.
module tb_mig_req_queue;
  logic mclk;
  logic mrst_n;
  int   n_pass;
  int   n_total;

  mig_req_queue_if #(.DEPTH_LOG2(3)) bus ();

  mig_req_queue #(.DEPTH_LOG2(3)) dut (
    .mclk   (mclk),
    .mrst_n (mrst_n),
    .q      (bus.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

`ifdef MIG_REQ_QUEUE_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle();
    bus.req_wen     = 1'b0;
    bus.req_waddr   = '0;
    bus.req_wrd_bwt = 1'b0;
    bus.req_wdata   = '0;
    bus.req_rnext   = 1'b0;
    bus.wdq_rnext   = 1'b0;
  endtask

  task automatic drive_push(input logic [31:0] addr, input logic rd, input logic [127:0] data);
    bus.req_wen     = 1'b1;
    bus.req_waddr   = addr;
    bus.req_wrd_bwt = rd;
    bus.req_wdata   = data;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    idle();
    mrst_n = 1'b0;
    #12;
    mrst_n = 1'b1;
    tick();

    // reset state
    check("rst_req_empty", bus.req_rqempty, 1);
    check("rst_wdq_empty", bus.wdq_rqempty, 1);
    check("rst_wfull", bus.req_wfull, 0);
    check("rst_count", bus.req_count, 0);
    check("rst_qerr", bus.q_err, 0);
    check("rst_qraddr", bus.req_qraddr, 0);
    check("rst_rd_bwt", bus.req_rd_bwt, 0);
    check("rst_wdata", bus.wdq_rdata, 0);

    // single write
    drive_push(32'h0000_1000, 1'b0, 128'hA5);
    tick();
    idle();
    check("w1_req_empty", bus.req_rqempty, 0);
    check("w1_wdq_empty", bus.wdq_rqempty, 0);
    check("w1_qraddr", bus.req_qraddr, 32'h1000);
    check("w1_rd_bwt", bus.req_rd_bwt, 0);
    check("w1_wdata", bus.wdq_rdata, 128'hA5);
    check("w1_count", bus.req_count, 1);
    bus.req_rnext = 1'b1;
    bus.wdq_rnext = 1'b1;
    tick();
    idle();
    check("w1_pop_req_empty", bus.req_rqempty, 1);
    check("w1_pop_wdq_empty", bus.wdq_rqempty, 1);

    // fill with 8 writes, 9th refused
    for (int i = 0; i < 8; i++) begin
      drive_push(32'h2000 + 32'(i * 16), 1'b0, 128'hC0DE_0000 + 128'(i));
      tick();
    end
    idle();
    check("fill_wfull", bus.req_wfull, 1);
    check("fill_count", bus.req_count, 8);
    drive_push(32'h0000_DEAD, 1'b0, 128'hDEAD);
    tick();
    idle();
    check("fill9_count", bus.req_count, 8);
    check("fill9_head", bus.req_qraddr, 32'h2000);
    for (int i = 0; i < 8; i++) begin
      check("fill_pop_addr", bus.req_qraddr, 32'h2000 + 32'(i * 16));
      check("fill_pop_data", bus.wdq_rdata, 128'hC0DE_0000 + 128'(i));
      bus.req_rnext = 1'b1;
      bus.wdq_rnext = 1'b1;
      tick();
    end
    idle();
    check("fill_end_req_empty", bus.req_rqempty, 1);
    check("fill_end_wdq_empty", bus.wdq_rqempty, 1);
    check("fill_end_count", bus.req_count, 0);

    // write-data queue full, request queue drained
    for (int i = 0; i < 8; i++) begin
      drive_push(32'h3000 + 32'(i), 1'b0, 128'hD0 + 128'(i));
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.req_rnext = 1'b1;
      tick();
    end
    idle();
    check("wdqf_req_empty", bus.req_rqempty, 1);
    check("wdqf_wdq_empty", bus.wdq_rqempty, 0);
    drive_push(32'h4000, 1'b1, '0);
    #1;
    check("wdqf_rd_wfull", bus.req_wfull, 0);
    tick();
    drive_push(32'h4100, 1'b0, 128'hBAD);
    #1;
    check("wdqf_wr_wfull", bus.req_wfull, 1);
    tick();
    idle();
    check("wdqf_count", bus.req_count, 1);
    check("wdqf_head_type", bus.req_rd_bwt, 1);
    check("wdqf_head_addr", bus.req_qraddr, 32'h4000);
    bus.req_rnext = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      check("wdqf_data", bus.wdq_rdata, 128'hD0 + 128'(i));
      bus.wdq_rnext = 1'b1;
      tick();
    end
    idle();
    check("wdqf_end_wdq_empty", bus.wdq_rqempty, 1);
    check("wdqf_end_req_empty", bus.req_rqempty, 1);

    // steady push+pop at count 4 across wrap
    begin
      int n;
      int k;
      n = 0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
        drive_push(32'h5000 + 32'(n), 1'b0, 128'hE000 + 128'(n));
        tick();
        n++;
      end
      idle();
      check("ss_start_count", bus.req_count, 4);
      for (int c = 0; c < 20; c++) begin
        check("ss_addr", bus.req_qraddr, 32'h5000 + 32'(k));
        check("ss_data", bus.wdq_rdata, 128'hE000 + 128'(k));
        drive_push(32'h5000 + 32'(n), 1'b0, 128'hE000 + 128'(n));
        bus.req_rnext = 1'b1;
        bus.wdq_rnext = 1'b1;
        tick();
        n++;
        k++;
        check("ss_count", bus.req_count, 4);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
        check("ss_drain_addr", bus.req_qraddr, 32'h5000 + 32'(k));
        bus.req_rnext = 1'b1;
        bus.wdq_rnext = 1'b1;
        tick();
        k++;
      end
      idle();
      check("ss_end_count", bus.req_count, 0);
    end

    // pop on empty with same-cycle push
    drive_push(32'h0000_0077, 1'b0, 128'h77);
    bus.req_rnext = 1'b1;
    bus.wdq_rnext = 1'b1;
    tick();
    idle();
    check("pe_count", bus.req_count, 1);
    check("pe_req_empty", bus.req_rqempty, 0);
    check("pe_wdq_empty", bus.wdq_rqempty, 0);
    check("pe_addr", bus.req_qraddr, 32'h77);
    check("pe_data", bus.wdq_rdata, 128'h77);
    check("pe_qerr", bus.q_err, ERR_EXP);
    tick();
    check("pe_qerr_hold", bus.q_err, ERR_EXP);

    // async reset with entries queued (1 already + 4 more = 5)
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h6000 + 32'(i), 1'b0, 128'h6000 + 128'(i));
      tick();
    end
    idle();
    check("ar_pre_count", bus.req_count, 5);
    #2;
    mrst_n = 1'b0;
    #1;
    check("ar_req_empty", bus.req_rqempty, 1);
    check("ar_wdq_empty", bus.wdq_rqempty, 1);
    check("ar_count", bus.req_count, 0);
    check("ar_qerr", bus.q_err, 0);
    #10;
    mrst_n = 1'b1;
    tick();
    check("ar_post_count", bus.req_count, 0);
    check("ar_post_qraddr", bus.req_qraddr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
